mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 The block SHALL have a parameter TIMEOUT, default 255, giving the maximum wait cycles for MemAck before a granted access is aborted.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RST, input, 1, synchronous active-high reset sampled on the rising edge of CLK.
REQ-004 The block SHALL have port IReqF, input, 1, fetch request from the F stage.
REQ-005 The block SHALL have port PCF, input, 32, fetch address.
REQ-006 The block SHALL have port InstrF, output, 32, fetched instruction, held until the next fetch completes.
REQ-007 The block SHALL have port IValidF, output, 1, one-cycle pulse when InstrF is updated.
REQ-008 The block SHALL have port MemWriteM, input, 1, store request from the M stage.
REQ-009 The block SHALL have port MemReadM, input, 1, load request from the M stage (decoded upstream from ResultSrcM = 2'b01).
REQ-010 The block SHALL have port ALUResultM, input, 32, data address.
REQ-011 The block SHALL have port WriteDataM, input, 32, store data.
REQ-012 The block SHALL have port ReadDataM, output, 32, load result, held until the next load completes.
REQ-013 The block SHALL have port DValidM, output, 1, one-cycle pulse when a load or store completes.
REQ-014 The block SHALL have port StallF, output, 1, which holds the PC and the IF/ID register.
REQ-015 The block SHALL have port StallM, output, 1, which holds the EX/MEM register and everything upstream of it.
REQ-016 The block SHALL have ports MemReq (output, 1), MemWe (output, 1), MemAddr (output, 32) and MemWData (output, 32), forming the single shared memory port request.
REQ-017 The block SHALL have ports MemRData (input, 32) and MemAck (input, 1), the memory response; MemAck marks the completion cycle.
REQ-018 The block SHALL have port ErrTimeout, output, 1, a sticky flag set when a MemAck timeout occurs.

Function
REQ-019 The FSM SHALL have three states: IDLE, FETCH and DATA.
REQ-020 In IDLE, a pending data request (MemWriteM|MemReadM) SHALL go to DATA, else IReqF SHALL go to FETCH, else the FSM SHALL stay in IDLE; data has priority when both requests are present.
REQ-021 On entry to FETCH, the block SHALL latch PCF into MemAddr and drive MemWe=0.
REQ-022 On entry to DATA, the block SHALL latch ALUResultM into MemAddr, WriteDataM into MemWData and MemWriteM into MemWe.
REQ-023 MemReq SHALL be 1 exactly while in FETCH or DATA, and MemAddr, MemWData and MemWe SHALL stay stable until the MemAck cycle.
REQ-024 In FETCH with MemAck=1, the block SHALL register MemRData into InstrF, pulse IValidF on the next cycle, and return to IDLE.
REQ-025 In DATA with MemAck=1, the block SHALL register MemRData into ReadDataM (loads only), pulse DValidM on the next cycle, and return to IDLE.
REQ-026 A MemAck received in IDLE SHALL be ignored.
REQ-027 StallM SHALL be computed combinationally as (MemWriteM|MemReadM) & !(state==DATA & MemAck).
REQ-028 StallF SHALL be computed combinationally as StallM | (IReqF & !(state==FETCH & MemAck)).
REQ-029 Minimum access latency SHALL be 2 cycles (grant cycle, then MemAck at the earliest on the next cycle); back-to-back accesses SHALL have one IDLE cycle between them.
REQ-030 A wait counter (8 bits, saturating) SHALL clear on entry to FETCH or DATA and increment each cycle without MemAck.
REQ-031 When the wait counter equals TIMEOUT, the block SHALL set ErrTimeout, deassert MemReq, return to IDLE without pulsing IValidF or DValidM, and retry the request under normal priority.
REQ-032 A data request arriving while in FETCH SHALL wait until the fetch completes; the fetch SHALL NOT be preempted.

Reset
REQ-033 When RST=1, on the next edge: state=IDLE; MemReq, MemWe, IValidF, DValidM and ErrTimeout=0; MemAddr, MemWData, InstrF, ReadDataM and the counter=0.
REQ-034 Reset asserted in FETCH or DATA SHALL abandon the access with no valid pulse; later MemAck SHALL be ignored.

Verification
REQ-035 Fetch only: IReqF=1, PCF=0x100, MemAck one cycle after grant with MemRData=0x00500093 -> MemAddr=0x100, MemWe=0, InstrF=0x00500093, IValidF pulses once, StallF low on the ack cycle.
REQ-036 Collision: IReqF=1 and MemReadM=1 with ALUResultM=0x2000 in the same IDLE cycle -> DATA is granted first, StallF stays high through the data access, and the fetch is granted after one IDLE cycle.
REQ-037 Store: MemWriteM=1, ALUResultM=0x40, WriteDataM=0xDEADBEEF, MemAck after 3 cycles -> MemWe=1 with stable address and data throughout, StallM high for 3 cycles, DValidM pulses, ReadDataM unchanged.
REQ-038 Timeout: TIMEOUT=4, no MemAck -> MemReq drops after 4 wait cycles, ErrTimeout=1 and stays 1, the request is reissued, and a later ack completes it normally.
REQ-039 Reset mid-DATA: assert RST with the FSM in DATA -> next cycle state=IDLE, MemReq=0, no DValidM, and a stray MemAck is ignored.
REQ-040 Data during fetch: MemReadM rises while in FETCH -> the fetch completes first and DATA is granted two cycles after the fetch MemAck.

Source files
------------

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// mem_port_arb : shares one memory port between instruction fetch and
//                load/store traffic; data wins collisions, fetch is never
//                preempted, and an unanswered access is dropped and retried.
// Revision     : 1.0
// ============================================================================
module mem_port_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        IValidF,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        DValidM,
  output logic        StallF,
  output logic        StallM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        ErrTimeout
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [7:0] c_timeout  = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ivalid_q, ivalid_d;
  logic        dvalid_q, dvalid_d;
  logic        err_q, err_d;

  logic        w_data_req;
  logic [7:0]  w_cnt_inc;

  assign w_data_req = MemWriteM | MemReadM;
  assign w_cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    instr_d  = instr_q;
    rdata_d  = rdata_q;
    ivalid_d = 1'b0;
    dvalid_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      c_st_idle: begin
        if (w_data_req) begin
          state_d = c_st_data;
          addr_d  = ALUResultM;
          wdata_d = WriteDataM;
          we_d    = MemWriteM;
          cnt_d   = 8'd0;
        end else if (IReqF) begin
          state_d = c_st_fetch;
          addr_d  = PCF;
          we_d    = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      c_st_fetch, c_st_data: begin
        if (MemAck) begin
          state_d = c_st_idle;
          if (state_q == c_st_fetch) begin
            instr_d  = MemRData;
            ivalid_d = 1'b1;
          end else begin
            dvalid_d = 1'b1;
            if (!we_q) rdata_d = MemRData;
          end
        end else begin
          // Abort lands in IDLE, where the still-pending request is re-arbitrated.
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == c_timeout) begin
            state_d = c_st_idle;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= c_st_idle;
      cnt_q    <= 8'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      instr_q  <= 32'd0;
      rdata_q  <= 32'd0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      ivalid_q <= ivalid_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
    end
  end

  assign MemReq     = (state_q == c_st_fetch) || (state_q == c_st_data);
  assign MemWe      = we_q;
  assign MemAddr    = addr_q;
  assign MemWData   = wdata_q;
  assign InstrF     = instr_q;
  assign IValidF    = ivalid_q;
  assign ReadDataM  = rdata_q;
  assign DValidM    = dvalid_q;
  assign ErrTimeout = err_q;
  assign StallM     = w_data_req & ~((state_q == c_st_data) & MemAck);
  assign StallF     = StallM | (IReqF & ~((state_q == c_st_fetch) & MemAck));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// tb_mem_port_arb : vector table, directed multi-cycle corner sequences and a
// randomized run compared against a transaction-level model.
module tb_mem_port_arb;
  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IReqF, MemWriteM, MemReadM, MemAck;
  logic [31:0] PCF, ALUResultM, WriteDataM, MemRData;
  logic [31:0] InstrF, ReadDataM, MemAddr, MemWData;
  logic        IValidF, DValidM, StallF, StallM, MemReq, MemWe, ErrTimeout;

  always #5 CLK = ~CLK;

  mem_port_arb #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .IReqF(IReqF), .PCF(PCF), .InstrF(InstrF), .IValidF(IValidF),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .DValidM(DValidM),
    .StallF(StallF), .StallM(StallM), .MemReq(MemReq), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .ErrTimeout(ErrTimeout)
  );

  int n_pass  = 0;
  int n_total = 0;
  int hi;

  typedef struct {
    logic        ireq;
    logic [31:0] pc;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rdat;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_stf;
    logic        e_stm;
    logic        e_iv;
    logic        e_dv;
    logic [31:0] e_instr;
    logic [31:0] e_rdm;
  } vec_t;

  vec_t vt [11];

  // transaction-level reference: 0 = no access, 1 = fetch, 2 = data
  int          m_kind, m_wait;
  logic [31:0] m_addr, m_wd, m_instr, m_rdm;
  logic        m_we, m_iv, m_dv, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    IReqF = 1'b0; PCF = 32'd0; MemWriteM = 1'b0; MemReadM = 1'b0;
    ALUResultM = 32'd0; WriteDataM = 32'd0; MemAck = 1'b0; MemRData = 32'd0;
  endtask

  task automatic model_reset();
    m_kind = 0; m_wait = 0; m_addr = 0; m_wd = 0; m_instr = 0; m_rdm = 0;
    m_we = 0; m_iv = 0; m_dv = 0; m_err = 0;
  endtask

  task automatic model_step();
    if (RST) begin
      model_reset();
    end else begin
      m_iv = 0;
      m_dv = 0;
      if (m_kind == 0) begin
        if (MemWriteM || MemReadM) begin
          m_kind = 2; m_addr = ALUResultM; m_wd = WriteDataM; m_we = MemWriteM; m_wait = 0;
        end else if (IReqF) begin
          m_kind = 1; m_addr = PCF; m_we = 0; m_wait = 0;
        end
      end else if (MemAck) begin
        if (m_kind == 1) begin
          m_instr = MemRData; m_iv = 1;
        end else begin
          m_dv = 1;
          if (!m_we) m_rdm = MemRData;
        end
        m_kind = 0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == int'(TMO)) begin
          m_err = 1; m_kind = 0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 32'h00500093,
               1'b1, 1'b0, 32'h100,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h00500093, 32'h0};
    vt[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0};
    vt[4]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0};
    vt[5]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h0};
    vt[6]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 32'hCAFEF00D,
               1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0};
    vt[7]  = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093, 32'hCAFEF00D};
    vt[8]  = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h200,  1'b1, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,    32'h0, 1'b1, 32'h12345678,
               1'b1, 1'b0, 32'h200,  1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'hCAFEF00D};
    vt[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'hCAFEF00D};

    idle_inputs();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    #3;
    chkb("rst MemReq", MemReq, 1'b0);
    chkb("rst MemWe", MemWe, 1'b0);
    chkb("rst IValidF", IValidF, 1'b0);
    chkb("rst DValidM", DValidM, 1'b0);
    chkb("rst ErrTimeout", ErrTimeout, 1'b0);
    chk("rst MemAddr", MemAddr, 32'h0);
    chk("rst MemWData", MemWData, 32'h0);
    chk("rst InstrF", InstrF, 32'h0);
    chk("rst ReadDataM", ReadDataM, 32'h0);
    tick();

    // fetch-only transaction followed by a fetch/data collision
    for (int i = 0; i < 11; i++) begin
      IReqF = vt[i].ireq; PCF = vt[i].pc; MemReadM = vt[i].rd; MemWriteM = vt[i].wr;
      ALUResultM = vt[i].alu; WriteDataM = vt[i].wd; MemAck = vt[i].ack; MemRData = vt[i].rdat;
      #3;
      chkb($sformatf("vec%0d MemReq", i), MemReq, vt[i].e_req);
      chkb($sformatf("vec%0d StallF", i), StallF, vt[i].e_stf);
      chkb($sformatf("vec%0d StallM", i), StallM, vt[i].e_stm);
      chkb($sformatf("vec%0d IValidF", i), IValidF, vt[i].e_iv);
      chkb($sformatf("vec%0d DValidM", i), DValidM, vt[i].e_dv);
      chk($sformatf("vec%0d InstrF", i), InstrF, vt[i].e_instr);
      chk($sformatf("vec%0d ReadDataM", i), ReadDataM, vt[i].e_rdm);
      if (vt[i].e_req) begin
        chk($sformatf("vec%0d MemAddr", i), MemAddr, vt[i].e_addr);
        chkb($sformatf("vec%0d MemWe", i), MemWe, vt[i].e_we);
      end
      tick();
    end

    // store with the ack on the third access cycle
    idle_inputs();
    MemWriteM = 1'b1; ALUResultM = 32'h40; WriteDataM = 32'hDEADBEEF;
    #3;
    chkb("st grant StallM", StallM, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      MemAck = (k == 2); MemRData = 32'h11111111;
      #3;
      chkb($sformatf("st%0d MemReq", k), MemReq, 1'b1);
      chkb($sformatf("st%0d MemWe", k), MemWe, 1'b1);
      chk($sformatf("st%0d MemAddr", k), MemAddr, 32'h40);
      chk($sformatf("st%0d MemWData", k), MemWData, 32'hDEADBEEF);
      chkb($sformatf("st%0d StallM", k), StallM, k != 2);
      tick();
    end
    idle_inputs();
    #3;
    chkb("st DValidM", DValidM, 1'b1);
    chk("st ReadDataM held", ReadDataM, 32'hCAFEF00D);
    chkb("st MemReq low", MemReq, 1'b0);
    tick();
    #3;
    chkb("st DValidM once", DValidM, 1'b0);
    tick();

    // fetch with no ack: abort, sticky error, retry
    IReqF = 1'b1; PCF = 32'h300;
    tick();
    #3;
    hi = 0;
    while (MemReq && hi < 20) begin
      hi++;
      chkb("to no IValidF", IValidF, 1'b0);
      tick();
      #3;
    end
    chk("to MemReq cycles", hi, 32'd4);
    chkb("to ErrTimeout set", ErrTimeout, 1'b1);
    chkb("to no IValidF after abort", IValidF, 1'b0);
    tick();
    #3;
    chkb("to retry MemReq", MemReq, 1'b1);
    chk("to retry MemAddr", MemAddr, 32'h300);
    MemAck = 1'b1; MemRData = 32'hA5A5A5A5;
    tick();
    idle_inputs();
    #3;
    chkb("to retry IValidF", IValidF, 1'b1);
    chk("to retry InstrF", InstrF, 32'hA5A5A5A5);
    chkb("to ErrTimeout sticky", ErrTimeout, 1'b1);
    tick();

    // reset while a data access is outstanding
    MemReadM = 1'b1; ALUResultM = 32'h500;
    tick();
    #3;
    chkb("rd DATA MemReq", MemReq, 1'b1);
    tick();
    RST = 1'b1; MemReadM = 1'b0;
    tick();
    RST = 1'b0;
    #3;
    chkb("rd MemReq after reset", MemReq, 1'b0);
    chkb("rd no DValidM", DValidM, 1'b0);
    chkb("rd ErrTimeout cleared", ErrTimeout, 1'b0);
    MemAck = 1'b1; MemRData = 32'h00000BAD;
    tick();
    MemAck = 1'b0;
    #3;
    chkb("rd stray ack MemReq", MemReq, 1'b0);
    chkb("rd stray ack DValidM", DValidM, 1'b0);
    chkb("rd stray ack IValidF", IValidF, 1'b0);
    chk("rd stray ack ReadDataM", ReadDataM, 32'h0);
    tick();

    // data request arriving mid-fetch waits for the fetch
    IReqF = 1'b1; PCF = 32'h600;
    tick();
    MemReadM = 1'b1; ALUResultM = 32'h700;
    #3;
    chkb("df fetch MemReq", MemReq, 1'b1);
    chk("df fetch MemAddr", MemAddr, 32'h600);
    chkb("df StallM", StallM, 1'b1);
    tick();
    MemAck = 1'b1; MemRData = 32'h00000013;
    #3;
    chk("df fetch not preempted", MemAddr, 32'h600);
    chkb("df fetch MemWe", MemWe, 1'b0);
    tick();
    MemAck = 1'b0; IReqF = 1'b0;
    #3;
    chkb("df gap MemReq", MemReq, 1'b0);
    chkb("df IValidF", IValidF, 1'b1);
    tick();
    #3;
    chkb("df DATA MemReq", MemReq, 1'b1);
    chk("df DATA MemAddr", MemAddr, 32'h700);
    MemAck = 1'b1; MemRData = 32'h00000077;
    tick();
    idle_inputs();
    #3;
    chkb("df DValidM", DValidM, 1'b1);
    chk("df ReadDataM", ReadDataM, 32'h00000077);
    tick();

    // randomized traffic against the reference model
    RST = 1'b1;
    tick();
    RST = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      IReqF      = ($urandom_range(0, 9) < 7);
      MemReadM   = ($urandom_range(0, 3) == 0);
      MemWriteM  = ($urandom_range(0, 3) == 0);
      PCF        = $urandom;
      ALUResultM = $urandom;
      WriteDataM = $urandom;
      MemAck     = ($urandom_range(0, 19) < 7);
      MemRData   = $urandom;
      RST        = ($urandom_range(0, 49) == 0);
      #3;
      chkb($sformatf("rnd%0d MemReq", c), MemReq, m_kind != 0);
      chkb($sformatf("rnd%0d IValidF", c), IValidF, m_iv);
      chkb($sformatf("rnd%0d DValidM", c), DValidM, m_dv);
      chkb($sformatf("rnd%0d ErrTimeout", c), ErrTimeout, m_err);
      chk($sformatf("rnd%0d InstrF", c), InstrF, m_instr);
      chk($sformatf("rnd%0d ReadDataM", c), ReadDataM, m_rdm);
      chkb($sformatf("rnd%0d StallM", c), StallM,
           (MemWriteM | MemReadM) & !(m_kind == 2 && MemAck));
      chkb($sformatf("rnd%0d StallF", c), StallF,
           ((MemWriteM | MemReadM) & !(m_kind == 2 && MemAck)) | (IReqF & !(m_kind == 1 && MemAck)));
      if (m_kind != 0) begin
        chk($sformatf("rnd%0d MemAddr", c), MemAddr, m_addr);
        chkb($sformatf("rnd%0d MemWe", c), MemWe, m_we);
        if (m_kind == 2) chk($sformatf("rnd%0d MemWData", c), MemWData, m_wd);
      end
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
